// File: rtl/oam_dma_ctrl.sv
// OAM DMA controller: a CPU write to TRIG_ADDR halts the CPU and copies one
// 256-byte page {page,00..FF} into the PPU OAM data port, one read then one
// write per byte, and then hands the bus back to the CPU.
module oam_dma_ctrl #(
  parameter logic [15:0] TRIG_ADDR = 16'h4014,
  parameter logic [15:0] OAM_ADDR  = 16'h2004
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_dout,
  input  logic        cpu_wr,
  input  logic [7:0]  mem_rd_data,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_din,
  output logic        mem_wr,
  output logic        cpu_rdy,
  output logic        dma_active
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic [7:0]  r_page;
  logic [7:0]  r_idx;
  logic        w_trig;

  // Trigger only recognised while idle; CPU inputs are ignored mid-transfer.
  assign w_trig = (r_state == IDLE) && cpu_wr && (cpu_addr == TRIG_ADDR);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Page latch and byte index; idx stops at FF so the copy never wraps.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_page <= '0;
      r_idx  <= '0;
    end else if (w_trig) begin
      r_page <= cpu_dout;
      r_idx  <= '0;
    end else if ((r_state == WRITE) && (r_idx != 8'hFF)) begin
      r_idx  <= r_idx + 8'd1;
    end
  end

  // Next state and bus mux: CPU pass-through when idle, DMA drives otherwise.
  always_comb begin
    w_next     = r_state;
    mem_addr   = cpu_addr;
    mem_din    = cpu_dout;
    mem_wr     = cpu_wr;
    cpu_rdy    = 1'b1;
    dma_active = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_trig) begin
          w_next = READ;
        end
      end
      READ: begin
        mem_addr   = {r_page, r_idx};
        mem_din    = 8'h00;
        mem_wr     = 1'b0;
        cpu_rdy    = 1'b0;
        dma_active = 1'b1;
        w_next     = WRITE;
      end
      WRITE: begin
        // Read data for {page,idx} arrives this cycle; forward it directly.
        mem_addr   = OAM_ADDR;
        mem_din    = mem_rd_data;
        mem_wr     = 1'b1;
        cpu_rdy    = 1'b0;
        dma_active = 1'b1;
        w_next     = (r_idx == 8'hFF) ? IDLE : READ;
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_oam_dma_ctrl.sv
// Bench for oam_dma_ctrl: table of idle/reset vectors, directed DMA
// sequences and randomized traffic, all checked cycle by cycle against a
// reference model that derives the expected bus from the cycle offset
// since the trigger.
module tb_oam_dma_ctrl;

  localparam logic [15:0] TRIG = 16'h4014;
  localparam logic [15:0] OAM  = 16'h2004;

  logic        clk;
  logic        rst;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_dout;
  logic        cpu_wr;
  logic [7:0]  mem_rd_data;
  logic [15:0] mem_addr;
  logic [7:0]  mem_din;
  logic        mem_wr;
  logic        cpu_rdy;
  logic        dma_active;

  oam_dma_ctrl #(.TRIG_ADDR(TRIG), .OAM_ADDR(OAM)) dut (
    .clk        (clk),
    .rst        (rst),
    .cpu_addr   (cpu_addr),
    .cpu_dout   (cpu_dout),
    .cpu_wr     (cpu_wr),
    .mem_rd_data(mem_rd_data),
    .mem_addr   (mem_addr),
    .mem_din    (mem_din),
    .mem_wr     (mem_wr),
    .cpu_rdy    (cpu_rdy),
    .dma_active (dma_active)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  // Memory: synchronous read, data valid the cycle after the address.
  logic [7:0] ram [0:65535];
  logic [7:0] oam_q [$];

  always @(posedge clk) begin
    mem_rd_data <= ram[mem_addr];
    if (mem_wr === 1'b1) begin
      if (mem_addr == OAM) oam_q.push_back(mem_din);
      else ram[mem_addr] <= mem_din;
    end
  end

  // Reference model: trigger cycle and page; everything else is arithmetic.
  int unsigned cyc;
  bit          m_active;
  int unsigned m_T;
  logic [7:0]  m_page;
  int          n_vec;
  int          n_miss;
  int          rdy_low;

  function automatic bit in_dma();
    return m_active && (cyc >= m_T + 1) && (cyc <= m_T + 512);
  endfunction

  task automatic model_exp(output logic [15:0] a, output logic [7:0] d,
                           output logic w, output logic r, output logic act);
    int unsigned off;
    int unsigned k;
    if (in_dma()) begin
      off = cyc - m_T;
      k   = (off - 1) / 2;
      if (off % 2 == 1) begin
        a = {m_page, 8'(k)};
        d = 8'h00;
        w = 1'b0;
      end else begin
        a = OAM;
        d = ram[{m_page, 8'(k)}];
        w = 1'b1;
      end
      r   = 1'b0;
      act = 1'b1;
    end else begin
      a   = cpu_addr;
      d   = cpu_dout;
      w   = cpu_wr;
      r   = 1'b1;
      act = 1'b0;
    end
  endtask

  task automatic check_bus(input string nm, input logic [15:0] ea, input logic [7:0] ed,
                           input logic ew, input logic er, input logic eact);
    n_vec++;
    if (mem_addr !== ea || mem_din !== ed || mem_wr !== ew ||
        cpu_rdy !== er || dma_active !== eact) begin
      n_miss++;
      $display("FAIL %s cyc=%0d got addr=%h din=%h wr=%b rdy=%b act=%b exp addr=%h din=%h wr=%b rdy=%b act=%b",
               nm, cyc, mem_addr, mem_din, mem_wr, cpu_rdy, dma_active, ea, ed, ew, er, eact);
    end
  endtask

  task automatic check_val(input string nm, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_miss++;
      $display("FAIL %s got=%0d exp=%0d", nm, got, exp);
    end
  endtask

  // Close the current cycle: advance the model at the clock edge.
  task automatic tick();
    @(posedge clk);
    if (rst) m_active = 1'b0;
    else if (!in_dma() && cpu_wr && cpu_addr == TRIG) begin
      m_active = 1'b1;
      m_T      = cyc;
      m_page   = cpu_dout;
    end
    cyc++;
    #1;
  endtask

  // One cycle of stimulus checked against the model.
  task automatic step(input logic r, input logic [15:0] a, input logic [7:0] d,
                      input logic w, input string nm);
    logic [15:0] ea;
    logic [7:0]  ed;
    logic        ew, er, eact;
    rst = r; cpu_addr = a; cpu_dout = d; cpu_wr = w;
    @(negedge clk);
    model_exp(ea, ed, ew, er, eact);
    check_bus(nm, ea, ed, ew, er, eact);
    if (cpu_rdy === 1'b0) rdy_low++;
    tick();
  endtask

  // Random CPU traffic kept away from the trigger and the preloaded pages.
  task automatic step_noise(input string nm);
    logic [15:0] a;
    a = 16'h3000 | 16'($urandom_range(0, 16'h0FFF));
    step(1'b0, a, 8'($urandom), 1'($urandom), nm);
  endtask

  typedef struct {
    string       name;
    logic        rst;
    logic [15:0] addr;
    logic [7:0]  dout;
    logic        wr;
    logic [15:0] e_addr;
    logic [7:0]  e_din;
    logic        e_wr;
    logic        e_rdy;
    logic        e_act;
  } vec_t;

  vec_t vecs [9];

  initial begin
    #5ms;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0] = '{"rd_0123",   1'b0, 16'h0123, 8'h00, 1'b0, 16'h0123, 8'h00, 1'b0, 1'b1, 1'b0};
    vecs[1] = '{"wr_0456",   1'b0, 16'h0456, 8'h55, 1'b1, 16'h0456, 8'h55, 1'b1, 1'b1, 1'b0};
    vecs[2] = '{"wr_4015",   1'b0, 16'h4015, 8'h02, 1'b1, 16'h4015, 8'h02, 1'b1, 1'b1, 1'b0};
    vecs[3] = '{"post_4015", 1'b0, 16'h0000, 8'h00, 1'b0, 16'h0000, 8'h00, 1'b0, 1'b1, 1'b0};
    vecs[4] = '{"wr_4013",   1'b0, 16'h4013, 8'h02, 1'b1, 16'h4013, 8'h02, 1'b1, 1'b1, 1'b0};
    vecs[5] = '{"post_4013", 1'b0, 16'hFFFF, 8'hAA, 1'b0, 16'hFFFF, 8'hAA, 1'b0, 1'b1, 1'b0};
    vecs[6] = '{"rst_trig",  1'b1, 16'h4014, 8'h02, 1'b1, 16'h4014, 8'h02, 1'b1, 1'b1, 1'b0};
    vecs[7] = '{"post_rst",  1'b0, 16'h1234, 8'h99, 1'b0, 16'h1234, 8'h99, 1'b0, 1'b1, 1'b0};
    vecs[8] = '{"rd_ffff",   1'b0, 16'hFFFF, 8'hFF, 1'b0, 16'hFFFF, 8'hFF, 1'b0, 1'b1, 1'b0};

    for (int i = 0; i < 65536; i++) ram[i] = 8'($urandom);
    for (int i = 0; i < 256; i++) begin
      ram[16'h0200 + i] = 8'(i);
      ram[16'hC000 + i] = 8'(i * 7 + 3);
    end

    n_vec = 0; n_miss = 0; cyc = 0; m_active = 1'b0; m_T = 0; m_page = 8'h00;
    rst = 1'b1; cpu_addr = 16'h0000; cpu_dout = 8'h00; cpu_wr = 1'b0;
    repeat (3) tick();

    step(1'b0, 16'h0000, 8'h00, 1'b0, "reset_state");

    // Idle pass-through, non-trigger addresses, trigger under reset.
    for (int i = 0; i < 9; i++) begin
      rst = vecs[i].rst; cpu_addr = vecs[i].addr; cpu_dout = vecs[i].dout; cpu_wr = vecs[i].wr;
      @(negedge clk);
      check_bus(vecs[i].name, vecs[i].e_addr, vecs[i].e_din, vecs[i].e_wr, vecs[i].e_rdy, vecs[i].e_act);
      tick();
    end

    // Page 02 copies 00..FF in order; CPU halted exactly 512 cycles.
    oam_q.delete(); rdy_low = 0;
    step(1'b0, TRIG, 8'h02, 1'b1, "trig_p02");
    for (int i = 1; i <= 520; i++) step_noise("dma_p02");
    check_val("p02_count", oam_q.size(), 256);
    begin
      int bad;
      bad = 0;
      for (int i = 0; i < oam_q.size() && i < 256; i++) if (oam_q[i] != 8'(i)) bad++;
      check_val("p02_data", bad, 0);
    end
    check_val("p02_rdy_low", rdy_low, 512);

    // Page C0 (ROM range) is accepted without any range check.
    oam_q.delete();
    step(1'b0, TRIG, 8'hC0, 1'b1, "trig_pC0");
    for (int i = 1; i <= 516; i++) step_noise("dma_pC0");
    check_val("pC0_count", oam_q.size(), 256);
    begin
      int bad;
      bad = 0;
      for (int i = 0; i < oam_q.size() && i < 256; i++) if (oam_q[i] != ram[16'hC000 + i]) bad++;
      check_val("pC0_data", bad, 0);
    end

    // Re-trigger mid-transfer with a different page is ignored.
    oam_q.delete();
    step(1'b0, TRIG, 8'h02, 1'b1, "trig_re");
    for (int i = 1; i <= 516; i++) begin
      if (i == 100) step(1'b0, TRIG, 8'h77, 1'b1, "retrig");
      else step_noise("dma_re");
    end
    check_val("re_count", oam_q.size(), 256);
    begin
      int bad;
      bad = 0;
      for (int i = 0; i < oam_q.size() && i < 256; i++) if (oam_q[i] != 8'(i)) bad++;
      check_val("re_data", bad, 0);
    end

    // Reset at T+301 aborts after 150 writes and does not resume.
    oam_q.delete();
    step(1'b0, TRIG, 8'hC0, 1'b1, "trig_rst");
    for (int i = 1; i <= 330; i++) begin
      if (i == 301) step(1'b1, 16'h3100, 8'h00, 1'b0, "abort_rst");
      else step_noise("dma_rst");
    end
    check_val("rst_count", oam_q.size(), 150);

    // Randomized traffic including triggers and occasional resets.
    for (int i = 0; i < 4000; i++) begin
      logic [15:0] a;
      a = ($urandom_range(0, 7) == 0) ? TRIG : 16'($urandom);
      step(1'($urandom_range(0, 699) == 0), a, 8'($urandom), 1'($urandom), "random");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/oam_dma_ctrl.md
OAM_DMA_CTRL -- requirements
Module: oam_dma_ctrl

Interface
REQ-001 The block SHALL have parameter TRIG_ADDR, default 16'h4014, meaning the CPU write address that starts a DMA.
REQ-002 The block SHALL have parameter OAM_ADDR, default 16'h2004, meaning the PPU OAM data port address that receives every DMA write.
REQ-003 The block SHALL have port clk, input, 1 bit: 50MHz system clock; all state changes on the rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 The block SHALL have port cpu_addr, input, 16 bits: CPU-requested memory address.
REQ-006 The block SHALL have port cpu_dout, input, 8 bits: CPU write data.
REQ-007 The block SHALL have port cpu_wr, input, 1 bit: CPU write enable.
REQ-008 The block SHALL have port mem_rd_data, input, 8 bits: read data from the memory controller, valid one cycle after the address is presented.
REQ-009 The block SHALL have port mem_addr, output, 16 bits: address to the memory controller.
REQ-010 The block SHALL have port mem_din, output, 8 bits: write data to the memory controller.
REQ-011 The block SHALL have port mem_wr, output, 1 bit: write enable to the memory controller.
REQ-012 The block SHALL have port cpu_rdy, output, 1 bit: 1 = CPU may run; 0 = CPU is halted.
REQ-013 The block SHALL have port dma_active, output, 1 bit: 1 while a transfer is in progress.

Function
REQ-014 The FSM SHALL have exactly three states: IDLE, READ and WRITE.
REQ-015 In IDLE, the mem_* outputs SHALL pass through the cpu_* inputs combinationally: mem_addr=cpu_addr, mem_din=cpu_dout, mem_wr=cpu_wr.
REQ-016 In IDLE, the block SHALL hold cpu_rdy=1 and dma_active=0.
REQ-017 The trigger SHALL be state==IDLE, cpu_wr=1 and cpu_addr==TRIG_ADDR. On the trigger, the CPU write SHALL still pass through to memory in that cycle.
REQ-018 On the trigger, the block SHALL latch page=cpu_dout[7:0], clear the 8-bit index idx to 0, and go to READ on the next edge.
REQ-019 In READ, the block SHALL drive mem_addr={page,idx}, mem_wr=0 and mem_din=8'h00, then go to WRITE.
REQ-020 In WRITE, the block SHALL drive mem_addr=OAM_ADDR, mem_wr=1 and mem_din=mem_rd_data. No extra data register is needed, because the read data returns in this cycle.
REQ-021 On leaving WRITE with idx!=8'hFF, the block SHALL increment idx and go to READ.
REQ-022 On leaving WRITE with idx==8'hFF, the block SHALL go to IDLE and SHALL NOT wrap idx into another pass.
REQ-023 In READ and WRITE, the block SHALL hold cpu_rdy=0 and dma_active=1, and SHALL ignore cpu_addr, cpu_dout and cpu_wr entirely.
REQ-024 A trigger write arriving while in READ or WRITE SHALL be ignored: no restart, no page change.
REQ-025 Latency: with the trigger in cycle T, reads SHALL occur at T+1+2k and writes at T+2+2k, for k=0..255.
REQ-026 cpu_rdy SHALL be 0 for exactly 512 cycles (T+1..T+512) and SHALL return to 1 at T+513.
REQ-027 Any page value 8'h00..8'hFF SHALL be accepted, including unmapped ranges; the block performs no range check.
REQ-028 mem_addr SHALL never leave page {page,8'h00}..{page,8'hFF} during READ.

Reset
REQ-029 When rst=1 at a clock edge, the block SHALL load state=IDLE, idx=0 and page=0, from any state including mid-transfer.
REQ-030 The cycle after reset, the block SHALL show cpu_rdy=1, dma_active=0, mem_wr=cpu_wr and mem_addr=cpu_addr.
REQ-031 A transfer interrupted by reset SHALL NOT resume; bytes already written remain written.
REQ-032 A trigger asserted in the same cycle as rst=1 SHALL be discarded.

Verification
REQ-033 Bench: preload RAM 0x0200..0x02FF with bytes 0x00..0xFF; CPU writes 0x02 to 0x4014 at cycle T -> 256 writes to 0x2004 carrying 0x00..0xFF in order at T+2+2k; cpu_rdy low T+1..T+512, high at T+513.
REQ-034 Bench: page=0xC0 (PRG-ROM HI) -> reads at 0xC000..0xC0FF, each followed by a write of that byte to 0x2004.
REQ-035 Bench: idle pass-through with CPU read 0x0123 and write 0x55 to 0x0456 -> mem_addr/mem_wr/mem_din mirror the CPU exactly, cpu_rdy=1.
REQ-036 Bench: second write to 0x4014 at T+100 with different data -> ignored; transfer completes from the original page at T+512.
REQ-037 Bench: rst=1 at T+301 -> state IDLE, cpu_rdy=1, dma_active=0 the next cycle; no further writes to 0x2004.
REQ-038 Bench: write to 0x4015 or 0x4013 -> no trigger; cpu_rdy stays 1.
